// File: rtl/vga_timing_pkg.sv
// Shared constants for vga_timing_gen: standard mode timings, sync polarities,
// the pipelined flag bundle and the colour-bar lookup used by VGA_TEST_PATTERN_EN.
package vga_timing_pkg;

    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FP     = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BP     = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FP     = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BP     = 33;
    localparam logic        VGA640_HS_POL   = POL_ACTIVE_LOW;
    localparam logic        VGA640_VS_POL   = POL_ACTIVE_LOW;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int unsigned SVGA800_H_ACTIVE = 800;
    localparam int unsigned SVGA800_H_FP     = 40;
    localparam int unsigned SVGA800_H_SYNC   = 128;
    localparam int unsigned SVGA800_H_BP     = 88;
    localparam int unsigned SVGA800_V_ACTIVE = 600;
    localparam int unsigned SVGA800_V_FP     = 1;
    localparam int unsigned SVGA800_V_SYNC   = 4;
    localparam int unsigned SVGA800_V_BP     = 23;
    localparam logic        SVGA800_HS_POL   = POL_ACTIVE_HIGH;
    localparam logic        SVGA800_VS_POL   = POL_ACTIVE_HIGH;

    localparam int unsigned BAR_COUNT = 8;

    // Raw per-pixel flags; hs/vs mean "inside the sync region", polarity applied at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic ls;
    } vga_flags_t;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } bar_rgb_t;

    function automatic bar_rgb_t colour_bar(input logic [2:0] idx);
        bar_rgb_t c;
        case (idx)
            3'd0:    c = '{r: 1'b1, g: 1'b1, b: 1'b1};
            3'd1:    c = '{r: 1'b1, g: 1'b1, b: 1'b0};
            3'd2:    c = '{r: 1'b0, g: 1'b1, b: 1'b1};
            3'd3:    c = '{r: 1'b0, g: 1'b1, b: 1'b0};
            3'd4:    c = '{r: 1'b1, g: 1'b0, b: 1'b1};
            3'd5:    c = '{r: 1'b1, g: 1'b0, b: 1'b0};
            3'd6:    c = '{r: 1'b0, g: 1'b0, b: 1'b1};
            default: c = '{r: 1'b0, g: 1'b0, b: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of configurable depth/width with asynchronous active-low clear.
// DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with LAT-cycle look-ahead pixel fetch.
// Optional built-in colour bars when VGA_TEST_PATTERN_EN is defined (adds test_mode input).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CW       = 12,
    parameter int unsigned DW       = 8,
    parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
    parameter int unsigned H_FP     = VGA640_H_FP,
    parameter int unsigned H_SYNC   = VGA640_H_SYNC,
    parameter int unsigned H_BP     = VGA640_H_BP,
    parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
    parameter int unsigned V_FP     = VGA640_V_FP,
    parameter int unsigned V_SYNC   = VGA640_V_SYNC,
    parameter int unsigned V_BP     = VGA640_V_BP,
    parameter logic        HS_POL   = VGA640_HS_POL,
    parameter logic        VS_POL   = VGA640_VS_POL,
    parameter int unsigned LAT      = 1
) (
    input  logic            pclk,
    input  logic            reset,
    input  logic            en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic            test_mode,
`endif
    input  logic [3*DW-1:0] vga_data,
    output logic            req,
    output logic [CW-1:0]   h_addr,
    output logic [CW-1:0]   v_addr,
    output logic            hsync,
    output logic            vsync,
    output logic            valid,
    output logic [DW-1:0]   vga_r,
    output logic [DW-1:0]   vga_g,
    output logic [DW-1:0]   vga_b,
    output logic            frame_start,
    output logic            line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (longint'(H_TOTAL) > (64'sd1 <<< CW)) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (longint'(V_TOTAL) > (64'sd1 <<< CW)) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (LAT > 8) begin : g_lat_chk
        $error("vga_timing_gen: LAT must be 0..8");
    end

    // Inclusive bounds keep every constant representable even when a total equals 2^CW.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    logic       h_act, v_act;
    vga_flags_t flags_raw, flags_dly;

    always_comb begin
        h_act        = (h_cnt_q <= H_ACT_LAST);
        v_act        = (v_cnt_q <= V_ACT_LAST);
        flags_raw    = '0;
        flags_raw.hs = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
        flags_raw.vs = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
        flags_raw.de = h_act && v_act;
        flags_raw.fs = (h_cnt_q == '0) && (v_cnt_q == '0);
        flags_raw.ls = (h_cnt_q == '0) && v_act;
    end

    assign req    = h_act && v_act;
    assign h_addr = req ? h_cnt_q : '0;
    assign v_addr = req ? v_cnt_q : '0;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned PIPE_W    = $bits(vga_flags_t) + 3;
    localparam int unsigned BAR_WIDTH = (H_ACTIVE / BAR_COUNT > 0) ? H_ACTIVE / BAR_COUNT : 1;
    localparam logic [CW-1:0] BAR_W_C = CW'(BAR_WIDTH);
    localparam logic [CW-1:0] BAR_MAX = CW'(BAR_COUNT - 1);

    logic [CW-1:0] bar_col;
    logic [2:0]    bar_idx, bar_idx_dly;

    always_comb begin
        bar_col = h_cnt_q / BAR_W_C;
        bar_idx = (bar_col > BAR_MAX) ? 3'd7 : bar_col[2:0];
    end
`else
    localparam int unsigned PIPE_W = $bits(vga_flags_t);
`endif

    logic [PIPE_W-1:0] pipe_in, pipe_out;

`ifdef VGA_TEST_PATTERN_EN
    // The bar index rides the same pipeline as the flags so bars respect LAT.
    assign pipe_in                  = {flags_raw, bar_idx};
    assign {flags_dly, bar_idx_dly} = pipe_out;
`else
    assign pipe_in   = flags_raw;
    assign flags_dly = vga_flags_t'(pipe_out);
`endif

    vga_delay_line #(
        .DEPTH (LAT),
        .WIDTH (PIPE_W)
    ) u_flag_dly (
        .clk_i  (pclk),
        .rst_ni (reset),
        .en_i   (en),
        .d_i    (pipe_in),
        .q_o    (pipe_out)
    );

    logic [3*DW-1:0] rgb_d, rgb_q;
    logic            hsync_q, vsync_q, valid_q, fs_q, ls_q;

    always_comb begin
        rgb_d = '0;
        if (flags_dly.de) begin
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode) begin
                rgb_d = {{DW{colour_bar(bar_idx_dly).r}},
                         {DW{colour_bar(bar_idx_dly).g}},
                         {DW{colour_bar(bar_idx_dly).b}}};
            end else begin
                rgb_d = vga_data;
            end
`else
            rgb_d = vga_data;
`endif
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            rgb_q   <= '0;
        end else if (en) begin
            hsync_q <= flags_dly.hs ? HS_POL : ~HS_POL;
            vsync_q <= flags_dly.vs ? VS_POL : ~VS_POL;
            valid_q <= flags_dly.de;
            fs_q    <= flags_dly.fs;
            ls_q    <= flags_dly.ls;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign valid       = valid_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign vga_r       = rgb_q[3*DW-1:2*DW];
    assign vga_g       = rgb_q[2*DW-1:DW];
    assign vga_b       = rgb_q[DW-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a tiny 14x7 raster with LAT=2 and a 2-cycle pixel source.
module tb_vga_timing_gen;

    localparam int H_A = 8, H_F = 2, H_S = 2, H_B = 2;
    localparam int V_A = 4, V_F = 1, V_S = 1, V_B = 1;
    localparam int HT = H_A + H_F + H_S + H_B;
    localparam int VT = V_A + V_F + V_S + V_B;
    localparam int FT = HT * VT;
    localparam int LATP = 2;
    localparam int CWP = 12;
    localparam int DWP = 8;

    logic            pclk = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b0;
    logic [3*DWP-1:0] vga_data = '0;
    logic            req;
    logic [CWP-1:0]  h_addr, v_addr;
    logic            hsync, vsync, valid, frame_start, line_start;
    logic [DWP-1:0]  vga_r, vga_g, vga_b;
`ifdef VGA_TEST_PATTERN_EN
    logic            test_mode = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int m = 0;
    int first_fs = -1;
    bit counting = 0;
    int hs_low = 0, vs_low = 0, de_cnt = 0, fs_cnt = 0, ls_cnt = 0;
    logic [3*DWP-1:0] s1 = '0, s2 = '0, addr_now;

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .CW(CWP), .DW(DWP),
        .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
        .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
        .HS_POL(1'b0), .VS_POL(1'b0), .LAT(LATP)
    ) dut (
        .pclk(pclk), .reset(reset), .en(en),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .vga_data(vga_data), .req(req), .h_addr(h_addr), .v_addr(v_addr),
        .hsync(hsync), .vsync(vsync), .valid(valid),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .line_start(line_start)
    );

    function automatic logic [23:0] src_word(input int h, input int v);
        logic [7:0] a;
        a = 8'((v % 16) * 16 + (h % 16));
        return {a, a, a};
    endfunction

    function automatic logic [23:0] bar_word(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t m=%0d)", tag, obs, exp, $time, m);
        end
    endtask

    // Reference: position p in the frame is simply (enabled edges since reset) mod FT;
    // outputs show the position LAT+1 enabled edges earlier.
    task automatic check_all();
        int p, h, v;
        logic e_de, e_hs, e_vs, e_fs, e_ls;
        logic [23:0] e_rgb;
        p = m % FT; h = p % HT; v = p / HT;
        e_de = (h < H_A) && (v < V_A);
        chk("req", 32'(req), 32'(e_de));
        chk("h_addr", 32'(h_addr), e_de ? 32'(h) : 32'd0);
        chk("v_addr", 32'(v_addr), e_de ? 32'(v) : 32'd0);
        if (m < LATP + 1) begin
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_ls = 1'b0; e_rgb = '0;
        end else begin
            p = (m - LATP - 1) % FT; h = p % HT; v = p / HT;
            e_de  = (h < H_A) && (v < V_A);
            e_hs  = !((h >= H_A + H_F) && (h < H_A + H_F + H_S));
            e_vs  = !((v >= V_A + V_F) && (v < V_A + V_F + V_S));
            e_fs  = (p == 0);
            e_ls  = (h == 0) && (v < V_A);
            e_rgb = e_de ? src_word(h, v) : 24'h0;
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode && e_de) e_rgb = bar_word(h);
`endif
        end
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("valid", 32'(valid), 32'(e_de));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("line_start", 32'(line_start), 32'(e_ls));
        chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
        if (counting) begin
            hs_low += (hsync == 1'b0) ? 1 : 0;
            vs_low += (vsync == 1'b0) ? 1 : 0;
            de_cnt += valid ? 1 : 0;
            fs_cnt += frame_start ? 1 : 0;
            ls_cnt += line_start ? 1 : 0;
        end
        if (frame_start && first_fs < 0) first_fs = m;
    endtask

    // Source model: 2-stage pipeline returning {a,a,a} for requests, junk when idle.
    task automatic cycle(input logic en_v);
        @(negedge pclk);
        check_all();
        addr_now = req ? src_word(int'(h_addr), int'(v_addr)) : 24'($urandom);
        en = en_v;
        @(posedge pclk);
        if (en_v && reset) begin
            s2 = s1;
            s1 = addr_now;
            m++;
        end
        #1 vga_data = s2;
    endtask

    task automatic async_reset_and_release();
        @(negedge pclk);
        #2 reset = 1'b0;
        m = 0;
        #1 check_all();
        cycle(1'b1);
        cycle(1'b1);
        reset = 1'b1;
        first_fs = -1;
        for (int k = 0; k < 8; k++) cycle(1'b1);
        chk("first_frame_start_edge", 32'(first_fs), 32'(LATP + 1));
    endtask

    initial begin
        #2 reset = 1'b0;
        #1 check_all();
        cycle(1'b0);
        cycle(1'b1);
        reset = 1'b1;
        first_fs = -1;
        for (int k = 0; k < 8; k++) cycle(1'b1);
        chk("first_frame_start_edge", 32'(first_fs), 32'(LATP + 1));

        counting = 1;
        for (int k = 0; k < 3 * FT; k++) cycle(1'b1);
        counting = 0;
        chk("hsync_low_3frames", 32'(hs_low), 32'(3 * VT * H_S));
        chk("vsync_low_3frames", 32'(vs_low), 32'(3 * V_S * HT));
        chk("valid_3frames", 32'(de_cnt), 32'(3 * H_A * V_A));
        chk("frame_start_3frames", 32'(fs_cnt), 32'd3);
        chk("line_start_3frames", 32'(ls_cnt), 32'(3 * V_A));

        for (int k = 0; k < 400; k++) cycle($urandom_range(0, 3) != 0);

        for (int k = 0; k < FT && !(((m % FT) % HT) == 3 && ((m % FT) / HT) == 1); k++) cycle(1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b0);
        for (int k = 0; k < 30; k++) cycle(1'b1);

        for (int k = 0; k < FT && (m % FT) != FT - 1; k++) cycle(1'b1);
        chk("model_at_frame_end", 32'(m % FT), 32'(FT - 1));
        hs_low = 0; vs_low = 0; de_cnt = 0; fs_cnt = 0; ls_cnt = 0;
        counting = 1;
        for (int k = 0; k < 6; k++) cycle(1'b1);
        counting = 0;
        chk("frame_start_once_after_wrap", 32'(fs_cnt), 32'd1);

        for (int k = 0; k < FT && !(((m % FT) % HT) == 4 && ((m % FT) / HT) == 1); k++) cycle(1'b1);
        async_reset_and_release();
        for (int k = 0; k < 150; k++) cycle($urandom_range(0, 4) != 0);

`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b1;
        async_reset_and_release();
        for (int k = 0; k < 2 * FT; k++) cycle($urandom_range(0, 4) != 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
